seg7_to_hex_decoder: RTL and testbench
======================================

Name: seg7_to_hex_decoder

Overview:
- Reverse of the hex-to-7-segment encoder: samples a 7-bit active-low segment pattern and recovers the 4-bit hex digit.
- Filters out transients: a digit is reported only after the pattern has been identical for STABLE_SAMPLES consecutive strobes.
- Results go to the downstream consumer (display monitor / self-check logic) through a valid/ready handshake.
- Flags illegal and blank patterns.

Parameters:
- STABLE_SAMPLES, 4, number of consecutive identical strobed samples required; legal range 2..15.
- CNT_W, 4, width of the match counter; must hold STABLE_SAMPLES.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- seg_in  input  7  segment pattern, active-low; bit6=g, bit5=f, bit4=e, bit3=d, bit2=c, bit1=b, bit0=a.
- seg_strobe  input  1  sample enable; seg_in is sampled only on cycles where this is high.
- hex_ready  input  1  consumer accepts the current result.
- hex_valid  output  1  result available; held until accepted.
- hex_data  output  4  decoded digit; 4'h0 when hex_err or hex_blank.
- hex_err  output  1  stable pattern is not one of the 16 codes and not blank.
- hex_blank  output  1  stable pattern is 7'b1111111.
- busy  output  1  high in SETTLE or PRESENT.

Behaviour:
- Reset (async, active-high): state=IDLE; hex_valid=0, hex_data=0, hex_err=0, hex_blank=0, busy=0; candidate=7'h7F, last_reported=7'h7F, count=0.
- Code table (seg_in -> hex_data):
  - 0:1000000, 1:1111001, 2:0100100, 3:0110000
  - 4:0011001, 5:0010010, 6:0000010, 7:1111000
  - 8:0000000, 9:0011000, A:0001000, B:0000011
  - C:1000110, D:0100001, E:0000110, F:0001110
- All outputs are registered.
- FSM:
  - IDLE: on strobe, candidate<=seg_in, count<=1, go to SETTLE.
  - SETTLE: on strobe with seg_in==candidate, count<=count+1. When count+1==STABLE_SAMPLES, decode candidate into the outputs, set hex_valid=1, go to PRESENT.
  - SETTLE: on strobe with seg_in!=candidate, candidate<=seg_in, count<=1; stay in SETTLE.
  - SETTLE: cycles without strobe change nothing; gaps between strobes do not break stability.
  - PRESENT: outputs stay constant; strobes are ignored. When hex_valid && hex_ready, hex_valid<=0, last_reported<=candidate, go to HOLD.
  - HOLD: on strobe with seg_in==last_reported, no action; the same digit is never reported twice in a row. On strobe with seg_in!=last_reported, candidate<=seg_in, count<=1, go to SETTLE.
- Latency: hex_valid rises on the cycle after the clock edge that samples the STABLE_SAMPLES-th matching strobe. Minimum is STABLE_SAMPLES cycles from the first strobe when strobe is held high.
- hex_ready already high when hex_valid rises: accepted on that first valid cycle (valid lasts exactly 1 cycle).
- hex_ready while hex_valid=0: ignored.
- Blank pattern: hex_valid=1, hex_blank=1, hex_err=0, hex_data=0.
- Illegal pattern: hex_valid=1, hex_err=1, hex_blank=0, hex_data=0.
- Exactly one of {legal digit, hex_err, hex_blank} applies per result.
- Reset asserted mid-SETTLE or mid-PRESENT: the pending result is discarded and hex_valid drops immediately (async).
- Counter never exceeds STABLE_SAMPLES; no wrap.

Optional Feature:
- Macro: SEG7_DEC_ERRCNT_EN.
- Defined: adds output err_count (8 bits).
  - Increments by 1 on each accepted result with hex_err=1.
  - Saturates at 8'hFF.
  - Cleared by reset only.
- Undefined: no err_count port and no counter logic.

Test Plan:
- STABLE_SAMPLES=4, strobe held high, seg_in=7'b0100100 for 4 cycles, hex_ready=1 -> hex_valid pulses 1 cycle with hex_data=4'h2, hex_err=0, hex_blank=0.
- seg_in sequence 0110000,0110000,0010010,0010010,0010010,0010010 (strobe each cycle) -> single result hex_data=4'h5; no 4'h3 emitted.
- After 4'hA accepted, seg_in=0001000 held 20 strobes -> no further hex_valid. Then 0000011 x4 -> hex_data=4'hB.
- seg_in=7'b1010101 x4 -> hex_err=1, hex_data=0. seg_in=7'b1111111 x4 -> hex_blank=1. With SEG7_DEC_ERRCNT_EN: err_count=1 after the first, unchanged after the blank.
- hex_ready=0 for 10 cycles after valid while seg_in changes -> outputs stable, still the first digit. Ready=1 -> accepted next edge.
- Reset pulse during SETTLE (count=3) -> all outputs 0 immediately. Then 3 matching strobes -> no valid; 4th -> valid.

Source files
------------

// File: rtl/seg7_to_hex_decoder_if.sv
// Result channel of the 7-segment to hex decoder.
// Handshake: hex_valid rises with the result and holds it steady until a clock edge sees
// hex_valid && hex_ready; that edge is the transfer. hex_ready is ignored while hex_valid is low.
interface seg7_to_hex_decoder_if;
   logic       hex_valid;
   logic       hex_ready;
   logic [3:0] hex_data;
   logic       hex_err;
   logic       hex_blank;

   modport master (output hex_valid, output hex_data, output hex_err, output hex_blank,
                   input hex_ready);
   modport slave  (input hex_valid, input hex_data, input hex_err, input hex_blank,
                   output hex_ready);
endinterface

// File: rtl/seg7_to_hex_decoder.sv
// Recovers a hex digit from a debounced active-low 7-segment pattern and hands it over by valid/ready.
// Optional macro SEG7_DEC_ERRCNT_EN adds an 8-bit saturating count of accepted illegal patterns.
module seg7_to_hex_decoder #(
   parameter int STABLE_SAMPLES = 4,
   parameter int CNT_W          = 4
) (
   input  logic                        clk,
   input  logic                        reset,
   input  logic [6:0]                  seg_in,
   input  logic                        seg_strobe,
   seg7_to_hex_decoder_if.master       hex,
   output logic                        busy,
   output logic [1:0]                  state_dbg
`ifdef SEG7_DEC_ERRCNT_EN
   ,
   output logic [7:0]                  err_count
`endif
);

   typedef enum logic [1:0] {IDLE = 2'd0, SETTLE = 2'd1, PRESENT = 2'd2, HOLD = 2'd3} state_t;

   state_t           state_q, state_d;
   logic [6:0]       cand_q, cand_d;
   logic [6:0]       last_q, last_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [CNT_W:0]   cnt_inc;
   logic             valid_q, valid_d;
   logic [3:0]       data_q, data_d;
   logic             err_q, err_d;
   logic             blank_q, blank_d;
   logic             busy_q;
   logic [5:0]       dec;
   logic             accept;

   // Result encoding {err, blank, data}; anything not blank and not in the table is an error.
   function automatic logic [5:0] decode(input logic [6:0] s);
      case (s)
         7'b1000000: decode = 6'h00;
         7'b1111001: decode = 6'h01;
         7'b0100100: decode = 6'h02;
         7'b0110000: decode = 6'h03;
         7'b0011001: decode = 6'h04;
         7'b0010010: decode = 6'h05;
         7'b0000010: decode = 6'h06;
         7'b1111000: decode = 6'h07;
         7'b0000000: decode = 6'h08;
         7'b0011000: decode = 6'h09;
         7'b0001000: decode = 6'h0A;
         7'b0000011: decode = 6'h0B;
         7'b1000110: decode = 6'h0C;
         7'b0100001: decode = 6'h0D;
         7'b0000110: decode = 6'h0E;
         7'b0001110: decode = 6'h0F;
         7'b1111111: decode = 6'b01_0000;
         default:    decode = 6'b10_0000;
      endcase
   endfunction

   assign dec     = decode(cand_q);
   assign cnt_inc = {1'b0, cnt_q} + {{CNT_W{1'b0}}, 1'b1};
   assign accept  = valid_q && hex.hex_ready;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) state_q <= IDLE;
      else       state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      cand_d  = cand_q;
      last_d  = last_q;
      cnt_d   = cnt_q;
      valid_d = valid_q;
      data_d  = data_q;
      err_d   = err_q;
      blank_d = blank_q;
      case (state_q)
         IDLE: begin
            if (seg_strobe) begin
               cand_d  = seg_in;
               cnt_d   = {{(CNT_W-1){1'b0}}, 1'b1};
               state_d = SETTLE;
            end
         end
         SETTLE: begin
            if (seg_strobe) begin
               if (seg_in == cand_q) begin
                  cnt_d = cnt_inc[CNT_W-1:0];
                  if (cnt_inc == (CNT_W+1)'(STABLE_SAMPLES)) begin
                     err_d   = dec[5];
                     blank_d = dec[4];
                     data_d  = dec[3:0];
                     valid_d = 1'b1;
                     state_d = PRESENT;
                  end
               end else begin
                  cand_d = seg_in;
                  cnt_d  = {{(CNT_W-1){1'b0}}, 1'b1};
               end
            end
         end
         PRESENT: begin
            if (accept) begin
               valid_d = 1'b0;
               last_d  = cand_q;
               state_d = HOLD;
            end
         end
         HOLD: begin
            // Re-arm only on a pattern change so one digit is never reported twice in a row.
            if (seg_strobe && (seg_in != last_q)) begin
               cand_d  = seg_in;
               cnt_d   = {{(CNT_W-1){1'b0}}, 1'b1};
               state_d = SETTLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cand_q  <= 7'h7F;
         last_q  <= 7'h7F;
         cnt_q   <= '0;
         valid_q <= 1'b0;
         data_q  <= 4'h0;
         err_q   <= 1'b0;
         blank_q <= 1'b0;
         busy_q  <= 1'b0;
      end else begin
         cand_q  <= cand_d;
         last_q  <= last_d;
         cnt_q   <= cnt_d;
         valid_q <= valid_d;
         data_q  <= data_d;
         err_q   <= err_d;
         blank_q <= blank_d;
         busy_q  <= (state_d == SETTLE) || (state_d == PRESENT);
      end
   end

`ifdef SEG7_DEC_ERRCNT_EN
   logic [7:0] err_cnt_q;
   always_ff @(posedge clk or posedge reset) begin
      if (reset)                                    err_cnt_q <= 8'h00;
      else if (accept && err_q && err_cnt_q != 8'hFF) err_cnt_q <= err_cnt_q + 8'h01;
   end
   assign err_count = err_cnt_q;
`endif

   assign hex.hex_valid = valid_q;
   assign hex.hex_data  = data_q;
   assign hex.hex_err   = err_q;
   assign hex.hex_blank = blank_q;
   assign busy          = busy_q;
   assign state_dbg     = state_q;

endmodule

// File: tb/tb_seg7_to_hex_decoder.sv
// Directed bench for seg7_to_hex_decoder: driver tasks push expected {err,blank,data}
// into a queue; a negedge monitor pops and compares on every accepted result.
module tb_seg7_to_hex_decoder;
  logic       clk = 1'b0;
  logic       reset;
  logic [6:0] seg_in;
  logic       seg_strobe;
  logic       busy;
  logic [1:0] state_dbg;
`ifdef SEG7_DEC_ERRCNT_EN
  logic [7:0] err_count;
`endif

  logic [5:0] exp_q[$];
  int n_tests = 0;
  int n_fail = 0;

  seg7_to_hex_decoder_if hif();

  seg7_to_hex_decoder #(.STABLE_SAMPLES(4), .CNT_W(4)) dut (
    .clk(clk),
    .reset(reset),
    .seg_in(seg_in),
    .seg_strobe(seg_strobe),
    .hex(hif),
    .busy(busy),
    .state_dbg(state_dbg)
`ifdef SEG7_DEC_ERRCNT_EN
    ,
    .err_count(err_count)
`endif
  );

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish within time limit");
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
    $fatal(1);
  end

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // driver tasks: inputs change #1 after the rising edge
  task automatic strobe_n(input logic [6:0] s, input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      seg_in = s;
      seg_strobe = 1'b1;
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      seg_strobe = 1'b0;
    end
  endtask

  // scoreboard monitor
  always @(negedge clk) begin
    logic [5:0] e;
    if (!reset && hif.hex_valid && hif.hex_ready) begin
      n_tests++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_result: got err=%0b blank=%0b data=%0h with nothing expected",
                 hif.hex_err, hif.hex_blank, hif.hex_data);
      end else begin
        e = exp_q.pop_front();
        if ({hif.hex_err, hif.hex_blank, hif.hex_data} !== e) begin
          n_fail++;
          $display("FAIL result: got err=%0b blank=%0b data=%0h expected err=%0b blank=%0b data=%0h",
                   hif.hex_err, hif.hex_blank, hif.hex_data, e[5], e[4], e[3:0]);
        end
      end
    end
  end

  initial begin
    reset = 1'b1;
    seg_in = 7'h7F;
    seg_strobe = 1'b0;
    hif.hex_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("reset_valid", {7'd0, hif.hex_valid}, 8'd0);
    check("reset_data", {4'd0, hif.hex_data}, 8'd0);
    check("reset_flags", {6'd0, hif.hex_err, hif.hex_blank}, 8'd0);
    check("reset_busy", {7'd0, busy}, 8'd0);
    check("reset_state", {6'd0, state_dbg}, 8'd0);
    reset = 1'b0;

    // digit 2, strobe held high, ready high: valid exactly one cycle, minimum latency
    exp_q.push_back(6'h02);
    strobe_n(7'b0100100, 4);
    idle(1);
    check("lat_valid_high", {7'd0, hif.hex_valid}, 8'd1);
    check("lat_busy_present", {7'd0, busy}, 8'd1);
    idle(1);
    check("pulse_valid_low", {7'd0, hif.hex_valid}, 8'd0);
    check("hold_state", {6'd0, state_dbg}, 8'd3);

    // transient 3 followed by stable 5: only 5 reported
    exp_q.push_back(6'h05);
    strobe_n(7'b0110000, 2);
    strobe_n(7'b0010010, 4);
    idle(3);

    // A, then same pattern 20 more strobes: no repeat; then B
    exp_q.push_back(6'h0A);
    strobe_n(7'b0001000, 24);
    idle(2);
    check("no_repeat_queue", exp_q.size(), 8'd0);
    exp_q.push_back(6'h0B);
    strobe_n(7'b0000011, 4);
    idle(3);

    // illegal, then blank
    exp_q.push_back(6'b10_0000);
    strobe_n(7'b1010101, 4);
    idle(3);
`ifdef SEG7_DEC_ERRCNT_EN
    check("errcnt_after_err", err_count, 8'd1);
`endif
    exp_q.push_back(6'b01_0000);
    strobe_n(7'b1111111, 4);
    idle(3);
`ifdef SEG7_DEC_ERRCNT_EN
    check("errcnt_after_blank", err_count, 8'd1);
`endif

    // backpressure: outputs stay put while seg_in keeps changing
    hif.hex_ready = 1'b0;
    exp_q.push_back(6'h01);
    strobe_n(7'b1111001, 4);
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      seg_in = (i % 2 == 0) ? 7'b0000000 : 7'b0001110;
      seg_strobe = 1'b1;
      check("bp_valid_held", {7'd0, hif.hex_valid}, 8'd1);
      check("bp_data_held", {4'd0, hif.hex_data}, 8'd1);
    end
    @(posedge clk); #1;
    seg_strobe = 1'b0;
    hif.hex_ready = 1'b1;
    idle(1);
    check("bp_accepted", {7'd0, hif.hex_valid}, 8'd0);

    // reset in SETTLE with count=3 discards the pending digit
    strobe_n(7'b0000110, 3);
    idle(1);
    check("settle_busy", {7'd0, busy}, 8'd1);
    reset = 1'b1;
    #1;
    check("rst_settle_busy", {7'd0, busy}, 8'd0);
    check("rst_settle_state", {6'd0, state_dbg}, 8'd0);
`ifdef SEG7_DEC_ERRCNT_EN
    check("rst_errcnt", err_count, 8'd0);
`endif
    reset = 1'b0;
    strobe_n(7'b0000110, 3);
    idle(2);
    check("three_strobes_no_valid", {7'd0, hif.hex_valid}, 8'd0);
    exp_q.push_back(6'h0E);
    strobe_n(7'b0000110, 1);
    idle(3);

    // reset while PRESENT drops valid immediately
    hif.hex_ready = 1'b0;
    strobe_n(7'b0011001, 4);
    idle(1);
    check("present_valid", {7'd0, hif.hex_valid}, 8'd1);
    reset = 1'b1;
    #1;
    check("rst_present_valid", {7'd0, hif.hex_valid}, 8'd0);
    check("rst_present_data", {4'd0, hif.hex_data}, 8'd0);
    reset = 1'b0;
    hif.hex_ready = 1'b1;

    // gaps between strobes do not break stability
    exp_q.push_back(6'h07);
    for (int i = 0; i < 4; i++) begin
      strobe_n(7'b1111000, 1);
      idle(2);
    end
    idle(3);

    check("queue_drained", exp_q.size(), 8'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
